mem_port_sched: RTL and testbench
=================================

Name: mem_port_sched

Overview:
- Scheduler sharing one single-port synchronous word RAM between KGP_RISC instruction fetch and load/store data accesses.
- Sits between the PC/fetch path, the LD/ST datapath (feeding the MemToReg load input) and the RAM.
- Serialises requests with fixed priority (data over fetch).
- Produces the stall that freezes the program counter and register write while an access is outstanding.

Parameters:
- ADDR_W, 10, RAM word-address width (depth 2^ADDR_W words)
- DATA_W, 32, data/instruction width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  32  byte address of instruction (from PC)
- if_ready  out  1  one-cycle pulse: if_instr valid
- if_instr  out  DATA_W  fetched instruction, registered, holds until next fetch completes
- d_rd  in  1  load request, level, held until d_ready
- d_wr  in  1  store request, level, held until d_ready
- d_addr  in  32  byte address of load/store (ALU result)
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: load data valid / store committed
- d_rdata  out  DATA_W  load data, registered, holds until next load completes
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address = byte_addr[ADDR_W+1:2]
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0
- stall  out  1  combinational: (if_req & ~if_ready) | ((d_rd|d_wr) & ~d_ready)
- misalign  out  1  one-cycle pulse: accepted request had byte_addr[1:0] != 0

Behaviour:
- Reset, asynchronous: state=IDLE; if_ready, d_ready, mem_en, mem_we, misalign = 0; if_instr, d_rdata, mem_addr, mem_wdata = 0.
- Reset mid-operation aborts the in-flight access and drops its result; requesters re-issue after reset.
- FSM states: IDLE, RD_I, RD_D, WR_D, DONE.
- RAM controls (mem_en, mem_we, mem_addr, mem_wdata) are registered, driven on the clock edge that leaves IDLE.
- IDLE, arbitration each cycle:
  - d_wr → WR_D (mem_en=1, mem_we=1).
  - else d_rd → RD_D (mem_en=1, mem_we=0).
  - else if_req → RD_I (mem_en=1, mem_we=0).
  - else stay in IDLE, mem_en=0.
- Data requests always win over a simultaneous fetch; the fetch waits in IDLE.
- d_rd & d_wr together: treated as a store, misalign not affected.
- RD_I: mem_rdata captured into if_instr; if_ready=1 for one cycle; mem_en=0; → DONE.
- RD_D: mem_rdata captured into d_rdata; d_ready=1; → DONE.
- WR_D: write already committed on entry edge; d_ready=1; mem_en=mem_we=0; → DONE.
- DONE: one cycle with no RAM access so the requester can drop or change its request; → IDLE.
- Latency from request seen in IDLE:
  - load/fetch: ready 2 cycles later.
  - store: ready 1 cycle later.
  - back-to-back throughput: one access per 3 cycles.
- Misaligned request: still accepted, address truncated (low 2 bits ignored); misalign pulses together with the ready pulse.
- Address bits above ADDR_W+1 are ignored (wrap-around within RAM).
- Requests deasserted before ready: the in-flight access still completes and the ready pulse is still issued; requesters must ignore it.

Optional Feature:
- Macro FETCH_BUF_EN.
- When defined:
  - A one-entry fetch buffer (valid bit, tag = word address, data) is loaded on every completed fetch.
  - In IDLE, with no data request, if_req whose word address matches a valid tag → DONE directly, if_ready=1 next cycle, if_instr = buffered data, no RAM access.
  - A store to the tagged word, or reset, clears valid.
- When undefined: every fetch accesses the RAM as above; no buffer logic is present.

Test Plan:
- Reset pulse mid-RD_D → all outputs 0 immediately, state IDLE; next d_rd at addr 0x8 returns RAM word 2 normally.
- RAM word 5 = 0x0C2100A5; if_req, if_addr=0x14 → mem_en at edge 1 with mem_addr=5; if_ready pulse at edge 2 with if_instr=0x0C2100A5; stall high until the pulse.
- Same-cycle if_req (addr 0x0) and d_wr (addr 0x40, data 0xDEADBEEF) → store first (mem_addr=16, mem_we=1), d_ready after 1 cycle; fetch issued after DONE, if_ready 5 cycles after start.
- d_wr 0x12345678 at 0x20, then d_rd at 0x20 → d_rdata=0x12345678; misalign stays 0.
- d_rd at addr 0x22 → word 8 read, misalign pulse coincident with d_ready.
- FETCH_BUF_EN: fetch 0x14 twice → second if_ready one cycle after request, mem_en stays 0; store to 0x14 then fetch 0x14 → RAM accessed again, new data returned.

Source files
------------

// File: rtl/mem_port_sched_if.sv
// rtl/mem_port_sched_if.sv - fetch, load/store and RAM signal bundle for mem_port_sched
interface mem_port_sched_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;

  logic              d_rd;
  logic              d_wr;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
  logic              misalign;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output if_ready, if_instr, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall, misalign
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_instr, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall, misalign
  );
endinterface

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - single-port RAM scheduler for fetch and load/store, data over fetch
// Define FETCH_BUF_EN to add a one-entry fetch buffer that bypasses the RAM on repeat fetches.
module mem_port_sched #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_sched_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD_I, RD_D, WR_D, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] if_word, d_word;
  logic              if_mis, d_mis;
  logic              pend_mis, pend_mis_n;
  logic              if_ready_n, d_ready_n, misalign_n;
  logic              mem_en_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_instr_n, d_rdata_n;
  logic              unused_hi_bits;

  assign if_word = bus.if_addr[ADDR_W+1:2];
  assign d_word  = bus.d_addr[ADDR_W+1:2];
  assign if_mis  = (bus.if_addr[1:0] != 2'b00);
  assign d_mis   = (bus.d_addr[1:0] != 2'b00);
  assign unused_hi_bits = ^{bus.if_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2]};

  assign bus.stall = (bus.if_req & ~bus.if_ready) | ((bus.d_rd | bus.d_wr) & ~bus.d_ready);

`ifdef FETCH_BUF_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag;
  logic [DATA_W-1:0] buf_data;
  logic              buf_hit;

  assign buf_hit = buf_valid && (buf_tag == if_word);

  // A store to the buffered word invalidates it so the next fetch sees the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == RD_I) begin
      buf_valid <= 1'b1;
      buf_tag   <= bus.mem_addr;
      buf_data  <= bus.mem_rdata;
    end else if (state == IDLE && bus.d_wr && d_word == buf_tag) begin
      buf_valid <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_n     = state;
    pend_mis_n  = pend_mis;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = bus.mem_addr;
    mem_wdata_n = bus.mem_wdata;
    if_ready_n  = 1'b0;
    d_ready_n   = 1'b0;
    misalign_n  = 1'b0;
    if_instr_n  = bus.if_instr;
    d_rdata_n   = bus.d_rdata;
    case (state)
      IDLE: begin
        if (bus.d_wr) begin
          // Store commits on this edge, so its ready pulse goes out immediately.
          state_n     = WR_D;
          mem_en_n    = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = d_word;
          mem_wdata_n = bus.d_wdata;
          d_ready_n   = 1'b1;
          misalign_n  = d_mis;
        end else if (bus.d_rd) begin
          state_n    = RD_D;
          mem_en_n   = 1'b1;
          mem_addr_n = d_word;
          pend_mis_n = d_mis;
        end else if (bus.if_req) begin
`ifdef FETCH_BUF_EN
          if (buf_hit) begin
            state_n    = DONE;
            if_instr_n = buf_data;
            if_ready_n = 1'b1;
            misalign_n = if_mis;
          end else
`endif
          begin
            state_n    = RD_I;
            mem_en_n   = 1'b1;
            mem_addr_n = if_word;
            pend_mis_n = if_mis;
          end
        end
      end
      RD_I: begin
        if_instr_n = bus.mem_rdata;
        if_ready_n = 1'b1;
        misalign_n = pend_mis;
        state_n    = DONE;
      end
      RD_D: begin
        d_rdata_n  = bus.mem_rdata;
        d_ready_n  = 1'b1;
        misalign_n = pend_mis;
        state_n    = DONE;
      end
      WR_D:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pend_mis      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.misalign  <= 1'b0;
      bus.if_instr  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      state         <= state_n;
      pend_mis      <= pend_mis_n;
      bus.mem_en    <= mem_en_n;
      bus.mem_we    <= mem_we_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_wdata <= mem_wdata_n;
      bus.if_ready  <= if_ready_n;
      bus.d_ready   <= d_ready_n;
      bus.misalign  <= misalign_n;
      bus.if_instr  <= if_instr_n;
      bus.d_rdata   <= d_rdata_n;
    end
  end
endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - randomized self-checking bench for mem_port_sched
module tb_mem_port_sched;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic load_ram;
  always #5 clk = ~clk;

  mem_port_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DATA_W-1:0] ram     [0:DEPTH-1];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];

  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;
  logic              fb_valid;
  logic [ADDR_W-1:0] fb_tag;
  logic [DATA_W-1:0] last_load, last_instr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fb_valid   = 1'b0;
    fb_tag     = '0;
    last_load  = '0;
    last_instr = '0;
  endtask

  // One transaction: requests raised together, held until their ready, outcome predicted up front.
  task automatic run(input logic f, input logic [31:0] fa, input logic rd, input logic wr,
                     input logic [31:0] da, input logic [31:0] wd);
    logic d_any, hit, f_mis, d_mis;
    logic [ADDR_W-1:0] fw, dw;
    logic [DATA_W-1:0] exp_rd, exp_ins;
    int d_exp, f_exp, en_exp, en_seen;
    d_any  = rd | wr;
    fw     = fa[ADDR_W+1:2];
    dw     = da[ADDR_W+1:2];
    f_mis  = (fa[1:0] != 2'b00);
    d_mis  = (da[1:0] != 2'b00);
    d_exp  = !d_any ? 0 : (wr ? 1 : 2);
    exp_rd = ref_mem[dw];
    if (wr) begin
      ref_mem[dw] = wd;
      if (fb_tag == dw) fb_valid = 1'b0;
    end
    hit = 1'b0;
`ifdef FETCH_BUF_EN
    hit = f && fb_valid && (fb_tag == fw);
`endif
    f_exp   = !f ? 0 : ((d_any ? 3 : 0) + (hit ? 1 : 2));
    exp_ins = ref_mem[fw];
    if (f) begin
      fb_valid = 1'b1;
      fb_tag   = fw;
    end
    en_exp  = int'(d_any) + int'(f && !hit);
    en_seen = 0;

    bus.if_req  = f;
    bus.if_addr = fa;
    bus.d_rd    = rd;
    bus.d_wr    = wr;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    #1 chk("stall_req", bus.stall, f | d_any);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      chk("stall", bus.stall, (f && cyc < f_exp) || (d_any && cyc < d_exp));
      chk("d_ready", bus.d_ready, d_any && cyc == d_exp);
      chk("if_ready", bus.if_ready, f && cyc == f_exp);
      chk("misalign", bus.misalign, (d_any && cyc == d_exp && d_mis) || (f && cyc == f_exp && f_mis));
      if (bus.mem_en) en_seen++;
      if (cyc == 1 && en_exp > 0) begin
        chk("mem_addr", bus.mem_addr, d_any ? dw : fw);
        chk("mem_we", bus.mem_we, wr);
        if (wr) chk("mem_wdata", bus.mem_wdata, wd);
      end
      if (d_any && cyc == d_exp) begin
        if (!wr) begin
          chk("d_rdata", bus.d_rdata, exp_rd);
          last_load = exp_rd;
        end
        bus.d_rd   = 1'b0;
        bus.d_wr   = 1'b0;
        bus.d_addr = $urandom;
      end
      if (f && cyc == f_exp) begin
        chk("if_instr", bus.if_instr, exp_ins);
        last_instr  = exp_ins;
        bus.if_req  = 1'b0;
        bus.if_addr = $urandom;
      end
    end
    chk("mem_en_cycles", en_seen, en_exp);
    chk("d_rdata_hold", bus.d_rdata, last_load);
    chk("if_instr_hold", bus.if_instr, last_instr);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic random_phase(input int n);
    int k;
    logic f, rd, wr;
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 4);
      f  = 1'($urandom_range(0, 1));
      rd = (k == 1);
      wr = (k == 2);
      run(f, rand_addr(), rd, wr, rand_addr(), $urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_if_ready"}, bus.if_ready, 0);
    chk({tag, "_d_ready"}, bus.d_ready, 0);
    chk({tag, "_misalign"}, bus.misalign, 0);
    chk({tag, "_if_instr"}, bus.if_instr, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[2] = 32'h2222_0002;
    ref_mem[5] = 32'h0C21_00A5;
    rst         = 1'b1;
    load_ram    = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    load_ram = 1'b0;
    check_all_zero("reset");
    chk("reset_stall", bus.stall, 0);
    rst = 1'b0;
    model_reset();

    run(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b1, 32'h0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    run(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
    run(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    run(1'b0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0);
    run(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 32'hCAFE_F00D);
    run(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    run(1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h0BAD_F00D);
    run(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_F030, 32'h0);
    run(1'b1, 32'h8, 1'b1, 1'b0, 32'h40, 32'h0);

    @(negedge clk);
    bus.d_rd   = 1'b1;
    bus.d_addr = 32'h8;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    bus.d_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);

    random_phase(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
